// File: rtl/ikbd_sci_rx.sv
// Byte FIFO with registered head/tail pointers and first-word-fall-through read.
// Latency: a push is visible at the head one clk after the push edge.
// Backpressure: a push into a full FIFO with no pop is dropped and flagged on drop_o.
module ikbd_sci_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [AW:0]   level_o,
  output logic          empty_o,
  output logic          drop_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         full;
  logic         do_pop;
  logic         do_push;

  // Extra pointer MSB separates full from empty.
  assign level_o    = wr_q - rd_q;
  assign empty_o    = (wr_q == rd_q);
  assign full       = (level_o == (AW+1)'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push    = push_i & (~full | do_pop);
  assign drop_o     = push_i & ~do_push;
  assign head_dat_o = mem_q[rd_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= push_dat_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// IKBD SCI receiver: 8N1 deserialiser with 16x oversampling feeding a byte FIFO.
// Latency: byte at FIFO head two clk after the stop-bit decision (tick 9 of stop).
// Backpressure: rx_valid/rx_ready; full FIFO drops the new byte and pulses overrun.
module ikbd_sci_rx #(
  parameter  int TICK_DIV   = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1,
  localparam int DW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          rxd,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic          frame_err,
  output logic          overrun,
  output logic [LW-1:0] level
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          sync1_q, rs_q, rs_prev_q;
  logic [DW-1:0] div_q, div_d;
  state_t        state_q, state_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    bit_q, bit_d;
  logic          s7_q, s7_d, s8_q, s8_d;
  logic [7:0]    sh_q, sh_d;
  logic          push_q, push_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q;
  logic          tick, start_edge, vote;
  logic          fifo_empty, fifo_drop;

  assign tick       = (div_q == DW'(TICK_DIV - 1));
  assign start_edge = (state_q == S_IDLE) & rs_prev_q & ~rs_q;
  assign vote       = (s7_q & s8_q) | (s7_q & rs_q) | (s8_q & rs_q);
  assign div_d      = (start_edge | tick) ? '0 : div_q + 1'b1;

  // Two-flop synchroniser plus a history flop for falling-edge detection.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync1_q   <= 1'b1;
      rs_q      <= 1'b1;
      rs_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      rs_q      <= sync1_q;
      rs_prev_q <= rs_q;
    end
  end

  // Oversample tick divider, realigned on every accepted start edge.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) div_q <= '0;
    else        div_q <= div_d;
  end

  // Receiver FSM and datapath registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= S_IDLE;
      sub_q   <= '0;
      bit_q   <= '0;
      s7_q    <= 1'b1;
      s8_q    <= 1'b1;
      sh_q    <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      sh_q    <= sh_d;
      push_q  <= push_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next state: samples at ticks 7/8, vote and act at tick 9, advance bit at tick 15.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    bit_d   = bit_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    sh_d    = sh_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d = S_START;
          sub_d   = '0;
        end
      end
      S_START, S_DATA, S_STOP: begin
        if (tick) begin
          sub_d = sub_q + 4'd1;
          if (sub_q == 4'd7) s7_d = rs_q;
          if (sub_q == 4'd8) s8_d = rs_q;
          if (sub_q == 4'd9) begin
            if (state_q == S_START && vote) begin
              state_d = S_IDLE;
            end else if (state_q == S_DATA) begin
              sh_d = {vote, sh_q[7:1]};
            end else if (state_q == S_STOP) begin
              if (vote) begin
                push_d  = 1'b1;
                state_d = S_IDLE;
              end else begin
                ferr_d  = 1'b1;
                state_d = S_BREAK;
                sub_d   = '0;
              end
            end
          end
          if (sub_q == 4'd15) begin
            if (state_q == S_START) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else if (state_q == S_DATA) begin
              if (bit_q == 3'd7) state_d = S_STOP;
              else               bit_d   = bit_q + 3'd1;
            end
          end
        end
      end
      S_BREAK: begin
        // Line must stay high for 16 consecutive ticks before re-arming.
        if (!rs_q) begin
          sub_d = '0;
        end else if (tick) begin
          if (sub_q == 4'd15) begin
            state_d = S_IDLE;
            sub_d   = '0;
          end else begin
            sub_d = sub_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  ikbd_sci_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .res_n      (res_n),
    .push_i     (push_q),
    .push_dat_i (sh_q),
    .pop_i      (rx_ready),
    .head_dat_o (rx_data),
    .level_o    (level),
    .empty_o    (fifo_empty),
    .drop_o     (fifo_drop)
  );

  // Registered overrun pulse for a byte lost to a full FIFO.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) ovr_q <= 1'b0;
    else        ovr_q <= fifo_drop;
  end

  assign rx_valid  = ~fifo_empty;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule
